// File: rtl/hilo_div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU, one quotient bit per clock.
// Drives the HI/LO write port: remainder on hi_o, quotient on lo_o.
module hilo_div #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          signed_i,
  input  logic [DW-1:0] opdata1_i,
  input  logic [DW-1:0] opdata2_i,
  input  logic          annul_i,
  output logic          busy_o,
  output logic          ready_o,
  output logic          hilo_we_o,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);

  localparam int unsigned CntW = (DW > 1) ? $clog2(DW) : 1;
  localparam int unsigned WW   = 2 * DW + 1;

  typedef enum logic [1:0] {
    StIdle,
    StDzero,
    StDiv,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [WW-1:0]   work_q, work_d;
  logic [DW-1:0]   divisor_q, divisor_d;
  logic            quot_neg_q, quot_neg_d;
  logic            rem_neg_q, rem_neg_d;
  logic [DW-1:0]   hi_q, hi_d;
  logic [DW-1:0]   lo_q, lo_d;

  logic            op1_neg, op2_neg;
  logic [DW-1:0]   op1_abs, op2_abs;
  logic [WW-1:0]   shifted;
  logic [DW+1:0]   trial;
  logic [WW-1:0]   step;
  logic [DW-1:0]   quot_raw, rem_raw;
  logic [DW-1:0]   quot_fix, rem_fix;

  assign op1_neg = signed_i & opdata1_i[DW-1];
  assign op2_neg = signed_i & opdata2_i[DW-1];
  assign op1_abs = op1_neg ? (-opdata1_i) : opdata1_i;
  assign op2_abs = op2_neg ? (-opdata2_i) : opdata2_i;

  // One restoring step: shift, trial-subtract from the upper DW+1 bits, keep if non-negative.
  assign shifted  = work_q << 1;
  assign trial    = {1'b0, shifted[WW-1:DW]} - {2'b00, divisor_q};
  assign step     = trial[DW+1] ? shifted : {trial[DW:0], shifted[DW-1:1], 1'b1};
  assign quot_raw = step[DW-1:0];
  assign rem_raw  = step[2*DW-1:DW];
  assign quot_fix = quot_neg_q ? (-quot_raw) : quot_raw;
  assign rem_fix  = rem_neg_q ? (-rem_raw) : rem_raw;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    divisor_d  = divisor_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    unique case (state_q)
      StIdle: begin
        if (start_i && !annul_i) begin
          quot_neg_d = op1_neg ^ op2_neg;
          rem_neg_d  = op1_neg;
          divisor_d  = op2_abs;
          cnt_d      = '0;
          if (opdata2_i == '0) begin
            // Divide-by-zero reports the raw dividend, so keep it unmodified.
            work_d  = {{(DW+1){1'b0}}, opdata1_i};
            state_d = StDzero;
          end else begin
            work_d  = {{(DW+1){1'b0}}, op1_abs};
            state_d = StDiv;
          end
        end
      end
      StDzero: begin
        if (annul_i) begin
          state_d = StIdle;
        end else begin
          hi_d    = work_q[DW-1:0];
          lo_d    = '1;
          state_d = StDone;
        end
      end
      StDiv: begin
        if (annul_i) begin
          state_d = StIdle;
        end else begin
          work_d = step;
          cnt_d  = cnt_q + CntW'(1);
          if (cnt_q == CntW'(DW - 1)) begin
            hi_d    = rem_fix;
            lo_d    = quot_fix;
            cnt_d   = '0;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      work_q     <= '0;
      divisor_q  <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      divisor_q  <= divisor_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy_o    = ((state_q == StIdle) && start_i && !annul_i) ||
                     (state_q == StDzero) || (state_q == StDiv);
  assign ready_o   = (state_q == StDone);
  assign hilo_we_o = ready_o;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;

endmodule
